// File: rtl/split_gate_dict_pkg.sv
// Shared types and constants for the split-gate lanes.
package split_gate_dict_pkg;

    typedef enum logic [1:0] {
        SEL_DROP = 2'd0,
        SEL_W    = 2'd1,
        SEL_R    = 2'd2,
        SEL_BOTH = 2'd3
    } sel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/split_gate_dict_if.sv
// Per-lane combined input and split w/r output channels, indexed by lane.
interface split_gate_dict_if #(
    parameter int NUM  = 4,
    parameter int BITS = 32
);
    logic [BITS-1:0] c           [NUM];
    logic [1:0]      c__sel      [NUM];
    logic            c__valid    [NUM];
    logic            c__ready    [NUM];
    logic [BITS-1:0] o__w        [NUM];
    logic [BITS-1:0] o__r        [NUM];
    logic            o__w__valid [NUM];
    logic            o__r__valid [NUM];
    logic            o__w__ready [NUM];
    logic            o__r__ready [NUM];

    modport master (
        output c, c__sel, c__valid, o__w__ready, o__r__ready,
        input  c__ready, o__w, o__r, o__w__valid, o__r__valid
    );

    modport slave (
        input  c, c__sel, c__valid, o__w__ready, o__r__ready,
        output c__ready, o__w, o__r, o__w__valid, o__r__valid
    );
endinterface

// File: rtl/_split_gate_lane.sv
// One lane: routes a combined word to a w stage, an r stage, both, or drops it.
// Optional drop counter under SPLIT_GATE_DICT_CNT_EN.
module _split_gate_lane
    import split_gate_dict_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS-1:0]       c_i,
    input  logic [1:0]            sel_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [BITS-1:0]       w_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [BITS-1:0]       r_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i
`ifdef SPLIT_GATE_DICT_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

    stage_t          w_st_q, r_st_q;
    logic [BITS-1:0] w_q, r_q;
    sel_t            sel;
    logic            can_w, can_r, accept, load_w, load_r;

    // Broadcast waits until both stages can take the word, so it is never split.
    always_comb begin
        sel   = sel_t'(sel_i);
        can_w = (w_st_q == ST_EMPTY) || w_ready_i;
        can_r = (r_st_q == ST_EMPTY) || r_ready_i;
        case (sel)
            SEL_W:    ready_o = can_w;
            SEL_R:    ready_o = can_r;
            SEL_BOTH: ready_o = can_w & can_r;
            default:  ready_o = 1'b1;
        endcase
        accept = valid_i & ready_o;
        load_w = accept & ((sel == SEL_W) || (sel == SEL_BOTH));
        load_r = accept & ((sel == SEL_R) || (sel == SEL_BOTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_st_q <= ST_EMPTY;
            r_st_q <= ST_EMPTY;
            w_q    <= '0;
            r_q    <= '0;
        end else begin
            if (load_w) begin
                w_st_q <= ST_FULL;
                w_q    <= c_i;
            end else if (w_ready_i) begin
                w_st_q <= ST_EMPTY;
            end
            if (load_r) begin
                r_st_q <= ST_FULL;
                r_q    <= c_i;
            end else if (r_ready_i) begin
                r_st_q <= ST_EMPTY;
            end
        end
    end

    assign w_o       = w_q;
    assign r_o       = r_q;
    assign w_valid_o = (w_st_q == ST_FULL);
    assign r_valid_o = (r_st_q == ST_FULL);

`ifdef SPLIT_GATE_DICT_CNT_EN
    logic [DROP_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (sel == SEL_DROP) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/_split_gate_dict.sv
// NUM independent split lanes behind one bus interface.
// Drop counters present only when SPLIT_GATE_DICT_CNT_EN is defined.
module _split_gate_dict
    import split_gate_dict_pkg::*;
#(
    parameter int NUM  = 4,
    parameter int BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    split_gate_dict_if.slave      bus
`ifdef SPLIT_GATE_DICT_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt [NUM]
`endif
);

    for (genvar k = 0; k < NUM; k++) begin : g_lane
        _split_gate_lane #(
            .BITS(BITS)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .c_i       (bus.c[k]),
            .sel_i     (bus.c__sel[k]),
            .valid_i   (bus.c__valid[k]),
            .ready_o   (bus.c__ready[k]),
            .w_o       (bus.o__w[k]),
            .w_valid_o (bus.o__w__valid[k]),
            .w_ready_i (bus.o__w__ready[k]),
            .r_o       (bus.o__r[k]),
            .r_valid_o (bus.o__r__valid[k]),
            .r_ready_i (bus.o__r__ready[k])
`ifdef SPLIT_GATE_DICT_CNT_EN
            ,
            .drop_cnt_o(drop_cnt[k])
`endif
        );
    end

endmodule
